// File: rtl/pll_mdrp_reconfig.sv
// Runtime PLL reconfiguration over MDRP: boot image, then requested divider sets,
// each byte verified by read-back, followed by PLL reset release and lock supervision.
module pll_mdrp_reconfig #(
  parameter int unsigned        NUM_CH       = 2,
  parameter logic [7:0]         INIT_FBDIV   = 8'd17,
  parameter logic [7:0]         INIT_IDIV    = 8'd0,
  parameter logic [NUM_CH*8-1:0] INIT_ODIV   = {NUM_CH{8'd7}},
  parameter int unsigned        RST_HOLD     = 16,
  parameter int unsigned        LOCK_TIMEOUT = 65535
) (
  input  logic                mdclk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [7:0]          cfg_fbdiv,
  input  logic [7:0]          cfg_idiv,
  input  logic [NUM_CH*8-1:0] cfg_odiv,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_code,
  output logic                pll_rst,
  input  logic                pll_lock,
  output logic                lock,
  output logic [1:0]          md_opc,
  output logic                md_ainc,
  output logic [7:0]          md_wdi,
  input  logic [7:0]          md_rdo
);

  localparam int unsigned NREG   = NUM_CH + 2;
  localparam int unsigned IW     = $clog2(NREG);
  localparam int unsigned TO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
  localparam int unsigned CW     = (TO_W > HOLD_W) ? TO_W : HOLD_W;
  localparam int unsigned IMG_W  = NREG * 8;

  localparam logic [IMG_W-1:0] INIT_IMG = {INIT_ODIV, INIT_IDIV, INIT_FBDIV};

  localparam logic [1:0] OpNop   = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpRead  = 2'b10;
  localparam logic [1:0] OpAclr  = 2'b11;

  typedef enum logic [3:0] {
    StIdle, StHold, StAclr, StWr, StRd, StChk, StInc, StRel, StWaitl, StLocked
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IMG_W-1:0] image_q, image_d;
  logic             lock_meta_q, lock_sync_q;
  logic             cfg_ready_q, cfg_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             pll_rst_q, pll_rst_d;
  logic [1:0]       md_opc_q, md_opc_d;
  logic             md_ainc_q, md_ainc_d;
  logic [7:0]       md_wdi_q, md_wdi_d;

  logic             accept;
  logic             timeout;
  logic [7:0]       cur_byte;

  assign accept   = cfg_valid && cfg_ready_q;
  assign cur_byte = image_q[8*idx_q +: 8];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    image_d    = image_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    timeout    = 1'b0;

    unique case (state_q)
      StIdle, StLocked: begin
        // A request wins over a same-cycle lock loss.
        if (accept) begin
          image_d    = {cfg_odiv, cfg_idiv, cfg_fbdiv};
          err_code_d = 2'd0;
          cnt_d      = '0;
          state_d    = StHold;
        end else if (state_q == StLocked && !lock_sync_q) begin
          state_d = StIdle;
        end
      end
      StHold: begin
        if (cnt_q == CW'(RST_HOLD - 1)) begin
          state_d = StAclr;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAclr: begin
        idx_d   = '0;
        state_d = StWr;
      end
      StWr:    state_d = StRd;
      StRd:    state_d = StChk;
      StChk: begin
        if (md_rdo != cur_byte) begin
          err_code_d = 2'd1;
          err_d      = 1'b1;
          state_d    = StIdle;
        end else if (idx_q == IW'(NREG - 1)) begin
          state_d = StRel;
        end else begin
          state_d = StInc;
        end
      end
      StInc: begin
        idx_d   = idx_q + 1'b1;
        state_d = StWr;
      end
      StRel: begin
        cnt_d   = '0;
        state_d = StWaitl;
      end
      StWaitl: begin
        // The REL cycle is the first released cycle, so the budget ends at LOCK_TIMEOUT-2.
        if (lock_sync_q) begin
          done_d  = 1'b1;
          state_d = StLocked;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 2)) begin
          err_code_d = 2'd2;
          err_d      = 1'b1;
          timeout    = 1'b1;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered outputs follow the state being entered.
    cfg_ready_d = (state_d == StIdle) || (state_d == StLocked);
    busy_d      = !cfg_ready_d;
    md_ainc_d   = (state_d == StInc);
    md_wdi_d    = (state_d == StWr) ? image_d[8*idx_d +: 8] : 8'h00;

    unique case (state_d)
      StAclr:  md_opc_d = OpAclr;
      StWr:    md_opc_d = OpWrite;
      StRd:    md_opc_d = OpRead;
      default: md_opc_d = OpNop;
    endcase

    unique case (state_d)
      StRel, StWaitl, StLocked: pll_rst_d = 1'b0;
      StIdle:                   pll_rst_d = timeout ? 1'b1 : pll_rst_q;
      default:                  pll_rst_d = 1'b1;
    endcase
  end

  always_ff @(posedge mdclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHold;
      cnt_q       <= '0;
      idx_q       <= '0;
      image_q     <= INIT_IMG;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      cfg_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
      pll_rst_q   <= 1'b1;
      md_opc_q    <= OpNop;
      md_ainc_q   <= 1'b0;
      md_wdi_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      image_q     <= image_d;
      lock_meta_q <= pll_lock;
      lock_sync_q <= lock_meta_q;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      pll_rst_q   <= pll_rst_d;
      md_opc_q    <= md_opc_d;
      md_ainc_q   <= md_ainc_d;
      md_wdi_q    <= md_wdi_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign pll_rst   = pll_rst_q;
  assign md_opc    = md_opc_q;
  assign md_ainc   = md_ainc_q;
  assign md_wdi    = md_wdi_q;
  // Lock must drop in the very cycle the synchronised lock falls.
  assign lock      = (state_q == StLocked) && lock_sync_q;

endmodule

// File: tb/tb_pll_mdrp_reconfig.sv
// Directed bench for pll_mdrp_reconfig with an MDRP register model and a PLL lock model.
module tb_pll_mdrp_reconfig;

  localparam int unsigned NUM_CH       = 2;
  localparam int unsigned RST_HOLD     = 16;
  localparam int unsigned LOCK_TIMEOUT = 200;

  logic                mdclk;
  logic                rst_n;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [7:0]          cfg_fbdiv;
  logic [7:0]          cfg_idiv;
  logic [NUM_CH*8-1:0] cfg_odiv;
  logic                busy;
  logic                done;
  logic                err;
  logic [1:0]          err_code;
  logic                pll_rst;
  logic                pll_lock;
  logic                lock;
  logic [1:0]          md_opc;
  logic                md_ainc;
  logic [7:0]          md_wdi;
  logic [7:0]          md_rdo;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  pll_mdrp_reconfig #(
    .NUM_CH      (NUM_CH),
    .RST_HOLD    (RST_HOLD),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .mdclk    (mdclk),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_fbdiv(cfg_fbdiv),
    .cfg_idiv (cfg_idiv),
    .cfg_odiv (cfg_odiv),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code),
    .pll_rst  (pll_rst),
    .pll_lock (pll_lock),
    .lock     (lock),
    .md_opc   (md_opc),
    .md_ainc  (md_ainc),
    .md_wdi   (md_wdi),
    .md_rdo   (md_rdo)
  );

  initial mdclk = 1'b0;
  always #5 mdclk = ~mdclk;
  always @(posedge mdclk) cyc <= cyc + 1;

  // MDRP register file model
  logic [7:0] mregs [0:7];
  logic [2:0] maddr = 3'd0;
  bit         corrupt_en = 1'b0;
  int         corrupt_idx = 0;
  initial md_rdo = 8'h00;

  always @(posedge mdclk) begin
    case (md_opc)
      2'b11: maddr <= 3'd0;
      2'b01: mregs[maddr] <= md_wdi;
      2'b10: md_rdo <= (corrupt_en && int'(maddr) == corrupt_idx) ? 8'hFF : mregs[maddr];
      default: ;
    endcase
    if (md_ainc) maddr <= maddr + 3'd1;
  end

  // PLL lock model: locks lock_delay cycles after reset release when enabled
  bit lock_en    = 1'b1;
  int lock_delay = 100;
  int lcnt       = 0;
  initial pll_lock = 1'b0;

  always @(posedge mdclk) begin
    if (pll_rst) begin
      lcnt     <= 0;
      pll_lock <= 1'b0;
    end else if (lock_en) begin
      if (lcnt == lock_delay) pll_lock <= 1'b1;
      else lcnt <= lcnt + 1;
    end
  end

  // Event monitor, sampled on the falling edge
  logic [7:0] wr_log [0:15];
  int wr_n, rd_n, aclr_n, ainc_n, done_n, err_n, acc_n;
  int rel_cyc, err_cyc, acc_cyc;
  logic prev_rst = 1'b1;

  always @(negedge mdclk) begin
    if (md_opc == 2'b01 && wr_n < 16) begin
      wr_log[wr_n] <= md_wdi;
      wr_n         <= wr_n + 1;
    end
    if (md_opc == 2'b10) rd_n <= rd_n + 1;
    if (md_opc == 2'b11) aclr_n <= aclr_n + 1;
    if (md_ainc) ainc_n <= ainc_n + 1;
    if (done) done_n <= done_n + 1;
    if (err) begin
      err_n   <= err_n + 1;
      err_cyc <= cyc;
    end
    if (cfg_valid && cfg_ready) begin
      acc_n   <= acc_n + 1;
      acc_cyc <= cyc;
    end
    if (prev_rst && !pll_rst) rel_cyc <= cyc;
    prev_rst <= pll_rst;
  end

  task automatic tick();
    @(posedge mdclk);
    #1;
  endtask

  task automatic clear_logs();
    wr_n = 0; rd_n = 0; aclr_n = 0; ainc_n = 0;
    done_n = 0; err_n = 0; acc_n = 0;
    rel_cyc = -1; err_cyc = -1; acc_cyc = -1;
    for (int i = 0; i < 16; i++) wr_log[i] = 8'hxx;
  endtask

  task automatic wait_done(input int max, output bit ok);
    int n0;
    n0 = done_n;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (done_n != n0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_err(input int max, output bit ok);
    int n0;
    n0 = err_n;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (err_n != n0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic request(input logic [7:0] fb, input logic [7:0] id, input logic [15:0] od);
    cfg_fbdiv = fb;
    cfg_idiv  = id;
    cfg_odiv  = od;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  localparam logic [18:0] RstExp = {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00};

  function automatic logic [18:0] out_vec();
    return {cfg_ready, busy, done, err, err_code, pll_rst, lock, md_opc, md_ainc, md_wdi};
  endfunction

  task automatic test_reset();
    logic [18:0] v;
    repeat (3) tick();
    v = out_vec();
    checks++;
    if (v !== RstExp) begin
      errors++;
      $display("FAIL reset_outputs got %h want %h", v, RstExp);
    end
  endtask

  task automatic test_boot();
    bit ok;
    logic [7:0] exp_b [4];
    exp_b = '{8'd17, 8'd0, 8'd7, 8'd7};
    clear_logs();
    rst_n = 1'b1;
    wait_done(600, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL boot_done_timeout got 0 want 1"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_log[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL boot_write%0d got %0d want %0d", i, wr_log[i], exp_b[i]);
      end
    end
    checks++;
    if (wr_n != 4 || rd_n != 4) begin
      errors++; $display("FAIL boot_wr_rd_count got %0d/%0d want 4/4", wr_n, rd_n);
    end
    checks++;
    if (aclr_n != 1) begin errors++; $display("FAIL boot_aclr got %0d want 1", aclr_n); end
    checks++;
    if (ainc_n != 3) begin errors++; $display("FAIL boot_ainc got %0d want 3", ainc_n); end
    checks++;
    if (done_n != 1) begin errors++; $display("FAIL boot_done_count got %0d want 1", done_n); end
    checks++;
    if ({lock, cfg_ready, busy, err_code} !== 5'b11000) begin
      errors++;
      $display("FAIL boot_status lock/ready/busy/code got %b%b%b%0d want 1100", lock, cfg_ready,
               busy, err_code);
    end
  endtask

  task automatic test_runtime();
    bit ok;
    logic [7:0] exp_b [4];
    exp_b = '{8'd24, 8'd1, 8'd5, 8'd3};
    clear_logs();
    checks++;
    if (lock !== 1'b1) begin errors++; $display("FAIL rt_lock_before got %b want 1", lock); end
    request(8'd24, 8'd1, {8'd3, 8'd5});
    checks++;
    if ({lock, busy, cfg_ready} !== 3'b010 || acc_n != 1) begin
      errors++;
      $display("FAIL rt_after_accept lock/busy/ready got %b%b%b acc %0d want 010 acc 1", lock,
               busy, cfg_ready, acc_n);
    end
    wait_done(600, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rt_done_timeout got 0 want 1"); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_log[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL rt_write%0d got %0d want %0d", i, wr_log[i], exp_b[i]);
      end
    end
    checks++;
    if (rel_cyc - acc_cyc != 1 + RST_HOLD + 1 + 4 * 4 - 1) begin
      errors++;
      $display("FAIL rt_latency got %0d want %0d", rel_cyc - acc_cyc, RST_HOLD + 17);
    end
    checks++;
    if (lock !== 1'b1 || done_n != 1) begin
      errors++; $display("FAIL rt_locked lock %b done %0d want 1 1", lock, done_n);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit rel_seen;
    logic [7:0] exp_b [4];
    exp_b = '{8'd30, 8'd2, 8'd6, 8'd4};
    clear_logs();
    cfg_fbdiv = 8'd30;
    cfg_idiv  = 8'd2;
    cfg_odiv  = {8'd4, 8'd6};
    cfg_valid = 1'b1;
    rel_seen  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (i == 5) cfg_fbdiv = 8'd99;
      if (!pll_rst) begin
        rel_seen = 1'b1;
        break;
      end
    end
    cfg_valid = 1'b0;
    checks++;
    if (!rel_seen) begin errors++; $display("FAIL b2b_rel_timeout got 0 want 1"); end
    wait_done(600, ok);
    checks++;
    if (!ok || acc_n != 1) begin
      errors++; $display("FAIL b2b_accepts got %0d done %0b want 1 1", acc_n, ok);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_log[i] !== exp_b[i]) begin
        errors++;
        $display("FAIL b2b_write%0d got %0d want %0d", i, wr_log[i], exp_b[i]);
      end
    end
  endtask

  task automatic test_verify_err();
    bit ok;
    clear_logs();
    corrupt_en  = 1'b1;
    corrupt_idx = 2;
    request(8'd20, 8'd0, {8'd7, 8'd7});
    wait_err(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL verr_err_timeout got 0 want 1"); end
    checks++;
    if (err_code !== 2'd1) begin
      errors++; $display("FAIL verr_code got %0d want 1", err_code);
    end
    checks++;
    if ({pll_rst, cfg_ready, lock} !== 3'b110) begin
      errors++; $display("FAIL verr_status rst/ready/lock got %b%b%b want 110", pll_rst, cfg_ready,
                         lock);
    end
    repeat (30) tick();
    checks++;
    if (wr_n != 3 || err_n != 1) begin
      errors++; $display("FAIL verr_writes got %0d err %0d want 3 1", wr_n, err_n);
    end
    corrupt_en = 1'b0;
    request(8'd17, 8'd0, {8'd7, 8'd7});
    checks++;
    if (err_code !== 2'd0) begin
      errors++; $display("FAIL verr_clear got %0d want 0", err_code);
    end
    wait_done(600, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL verr_recover_done got 0 want 1"); end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_logs();
    lock_en = 1'b0;
    request(8'd17, 8'd0, {8'd7, 8'd7});
    wait_err(600, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL to_err_timeout got 0 want 1"); end
    checks++;
    if (err_cyc - rel_cyc != LOCK_TIMEOUT) begin
      errors++; $display("FAIL to_delay got %0d want %0d", err_cyc - rel_cyc, LOCK_TIMEOUT);
    end
    checks++;
    if (err_code !== 2'd2) begin errors++; $display("FAIL to_code got %0d want 2", err_code); end
    checks++;
    if ({pll_rst, cfg_ready, busy} !== 3'b110 || done_n != 0) begin
      errors++;
      $display("FAIL to_status rst/ready/busy got %b%b%b done %0d want 110 0", pll_rst,
               cfg_ready, busy, done_n);
    end
  endtask

  task automatic test_rst_mid();
    bit ok;
    bit found;
    logic [18:0] v;
    lock_en = 1'b1;
    clear_logs();
    request(8'd9, 8'd4, {8'd7, 8'd7});
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (md_opc == 2'b01 && md_wdi == 8'd4) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mid_wr1_timeout got 0 want 1"); end
    #1 rst_n = 1'b0;
    #1 v = out_vec();
    checks++;
    if (v !== RstExp) begin
      errors++; $display("FAIL mid_reset_outputs got %h want %h", v, RstExp);
    end
    tick();
    tick();
    clear_logs();
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (wr_n >= 1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found || aclr_n != 1 || wr_log[0] !== 8'd17) begin
      errors++;
      $display("FAIL mid_restart found %0b aclr %0d wr0 %0d want 1 1 17", found, aclr_n,
               wr_log[0]);
    end
    wait_done(600, ok);
    checks++;
    if (!ok || lock !== 1'b1) begin
      errors++; $display("FAIL mid_relock got %0b lock %b want 1 1", ok, lock);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_fbdiv = 8'h00;
    cfg_idiv  = 8'h00;
    cfg_odiv  = '0;
    clear_logs();
    test_reset();
    test_boot();
    test_runtime();
    test_back_to_back();
    test_verify_err();
    test_timeout();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/pll_mdrp_reconfig.md
Name: pll_mdrp_reconfig

Overview:
- Parametrised runtime reconfiguration controller for a Gowin PLL through its MDRP port (opcode, address-increment, write data, read data).
- Successor to the fixed boot-time init: programs a power-up image from parameters, then accepts new FBDIV/IDIV/per-channel ODIV sets at runtime.
- Each write is verified by read-back; the block sequences PLL reset and supervises lock with a timeout.
- Sits between the PLL primitive and the system clock/reset manager, clocked by the MDRP clock.

Parameters:
- NUM_CH, 2, number of PLL output channels, 1..6; each gets one ODIV register.
- INIT_FBDIV, 8'd17, feedback divider written at boot (multiplier 18).
- INIT_IDIV, 8'd0, input divider written at boot.
- INIT_ODIV, {NUM_CH{8'd7}}, boot output dividers, channel 0 in the LSB byte.
- RST_HOLD, 16, cycles pll_rst is held before MDRP access.
- LOCK_TIMEOUT, 65535, cycles allowed for lock after reset release; width = $clog2(LOCK_TIMEOUT+1).

Ports:
- mdclk  in  1  MDRP/controller clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  new configuration request.
- cfg_ready  out  1  high in IDLE and LOCKED only.
- cfg_fbdiv  in  8  feedback divider.
- cfg_idiv  in  8  input divider.
- cfg_odiv  in  NUM_CH*8  output dividers.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse on successful lock.
- err  out  1  one-cycle pulse on failure.
- err_code  out  2  0 none, 1 verify mismatch, 2 lock timeout; held until the next accepted request.
- pll_rst  out  1  PLL reset, active high.
- pll_lock  in  1  raw PLL lock; asynchronous, 2-flop synchronised internally.
- lock  out  1  qualified lock.
- md_opc  out  2  00 NOP, 01 WRITE, 10 READ, 11 ADDR_CLR.
- md_ainc  out  1  address-increment pulse.
- md_wdi  out  8  write data.
- md_rdo  in  8  read data, valid one cycle after READ.

Behaviour:
- Reset values: cfg_ready=0, busy=1, done=0, err=0, err_code=0, pll_rst=1, lock=0, md_opc=00, md_ainc=0, md_wdi=0.
- After rst_n deasserts, the block automatically runs the full sequence with the INIT_* image.
- Register image: index 0 = FBDIV, 1 = IDIV, 2..NUM_CH+1 = ODIV[ch]. NREG = NUM_CH+2.
- A request is accepted on cfg_valid && cfg_ready. All cfg_* buses are captured into an internal image that cycle; later input changes are ignored until the next accept.
- States:
  - IDLE: no lock yet or after error.
  - HOLD: pll_rst=1, lock=0, busy=1; count RST_HOLD cycles.
  - ACLR: md_opc=11 for one cycle; idx=0.
  - WR: md_opc=01, md_wdi=image[idx], one cycle.
  - RD: md_opc=10, one cycle.
  - CHK: md_opc=00. If md_rdo != image[idx], set err_code=1, pulse err, go to IDLE with pll_rst still 1. Otherwise, if idx==NREG-1 go to REL; else go to INC.
  - INC: md_ainc=1 for one cycle; idx++; go to WR.
  - REL: pll_rst=0; clear the timeout counter.
  - WAITL: wait for synchronised lock. If it is seen, go to LOCKED and pulse done. If the counter reaches LOCK_TIMEOUT, set err_code=2, pulse err, assert pll_rst=1, go to IDLE.
  - LOCKED: lock=1 while synchronised lock stays high, cfg_ready=1, busy=0.
- In LOCKED, if synchronised lock drops: lock=0 the same cycle, with no automatic retry.
- Per-register cost: 4 cycles (WR, RD, CHK, INC), except the last register, which has no INC.
- Sequence latency from accept to REL: 1 + RST_HOLD + 1 + 4·NREG − 1 cycles.
- Simultaneous events:
  - cfg_valid in the same cycle lock drops in LOCKED: the request is accepted (reprogram).
  - cfg_valid while busy: ignored, with no queueing.
- Lock supervision: pll_lock glitches in WAITL count only after synchronisation; lock qualifies on the first synchronised-high cycle.
- Accepting a new request clears err_code to 0.
- rst_n asserted mid-sequence: outputs return to reset values immediately and asynchronously. The idx and counters clear; after release the boot sequence restarts.

Test Plan:
- Boot, NUM_CH=2, RST_HOLD=16; PLL model locks 100 cycles after release -> 4 bytes written then read back (17, 0, 7, 7); ACLR seen once; exactly 3 md_ainc pulses; done pulses once; lock=1; cfg_ready=1.
- Runtime request with fbdiv=24, idiv=1, odiv={8'd3,8'd5} while LOCKED -> lock falls the cycle after accept; image written as 24, 1, 5, 3; done pulses; lock=1.
- Model corrupts the read-back of register 2 (returns 8'hFF) -> err pulses; err_code=1; pll_rst stays 1; no further MDRP writes; the next request clears err_code.
- Model never locks, LOCK_TIMEOUT=200 -> err pulses exactly 200 cycles after REL; err_code=2; pll_rst=1; cfg_ready=1.
- rst_n pulsed low during the WR of index 1 -> all outputs return to reset values the same cycle; after release, ACLR is followed by a write of index 0 again.
- cfg_valid held high during the whole sequence -> only one accept; changes to cfg_fbdiv mid-sequence are not written.
